// File: rtl/vending_ctrl_param_pkg.sv
// Shared types and constants for the parametrised vending controller.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package vending_ctrl_param_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_t;

  localparam int COIN5_VAL  = 5;
  localparam int COIN10_VAL = 10;

  // Value of the coins pulsed this cycle; both together are worth 15.
  function automatic logic [3:0] coin_sum(input logic c5, input logic c10);
    logic [3:0] s;
    s = 4'd0;
    if (c5)  s = s + 4'(COIN5_VAL);
    if (c10) s = s + 4'(COIN10_VAL);
    return s;
  endfunction

endpackage

// File: rtl/vending_ctrl_param_if.sv
// Front-end / hopper signal bundle of the vending controller.
// Latency: none (wiring only).
// Backpressure: hopper_ready qualifies chg5/chg10; everything else is pulse based.
interface vending_ctrl_param_if #(
  parameter int SEL_W    = 2,
  parameter int CREDIT_W = 8
);
  logic                coin5;
  logic                coin10;
  logic                sel_valid;
  logic [SEL_W-1:0]    sel;
  logic                cancel;
  logic                hopper_ready;
  logic                vend_valid;
  logic [SEL_W-1:0]    vend_id;
  logic                chg5;
  logic                chg10;
  logic                coin_reject;
  logic                sel_err;
  logic [CREDIT_W-1:0] credit;
  logic                busy;

  // Front end and hopper driver side.
  modport master (
    output coin5, coin10, sel_valid, sel, cancel, hopper_ready,
    input  vend_valid, vend_id, chg5, chg10, coin_reject, sel_err, credit, busy
  );

  // Controller side.
  modport slave (
    input  coin5, coin10, sel_valid, sel, cancel, hopper_ready,
    output vend_valid, vend_id, chg5, chg10, coin_reject, sel_err, credit, busy
  );
endinterface

// File: rtl/vending_ctrl_param_change_dispenser.sv
// Pays a loaded amount out as 10/5 coins, largest first, one coin per hopper beat.
// Latency: first coin offered the cycle after load; one coin per hopper_ready cycle.
// Backpressure: hopper_ready low holds the remaining amount indefinitely.
module vending_ctrl_param_change_dispenser
  import vending_ctrl_param_pkg::*;
#(
  parameter int CREDIT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [CREDIT_W-1:0] amount,
  input  logic                hopper_ready,
  output logic                chg5,
  output logic                chg10,
  output logic                done,
  output logic [CREDIT_W-1:0] remaining
);

  localparam logic [CREDIT_W-1:0] FIVE = CREDIT_W'(COIN5_VAL);
  localparam logic [CREDIT_W-1:0] TEN  = CREDIT_W'(COIN10_VAL);

  logic [CREDIT_W-1:0] rem;
  logic [CREDIT_W-1:0] step;
  logic                pay;
  logic                big;

  // The coin choice comes from the register, but the strobe is qualified by
  // hopper_ready in the same cycle so a coin is never offered to a busy hopper.
  assign pay       = (rem != '0) && hopper_ready;
  assign big       = (rem >= TEN);
  assign step      = big ? TEN : FIVE;
  assign chg10     = pay && big;
  assign chg5      = pay && !big;
  assign done      = pay && (rem <= step);
  assign remaining = rem;

  // Remaining-amount register: loaded once, then drained one coin per beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem <= '0;
    end else if (load) begin
      rem <= amount;
    end else if (pay) begin
      rem <= (rem <= step) ? '0 : rem - step;
    end
  end

endmodule

// File: rtl/vending_ctrl_param.sv
// Coin vending controller: accumulates 5/10 credit, vends NUM_PROD priced products, pays change.
// Latency: every response pulse is registered, one cycle after the input pulse.
// Backpressure: only the change hopper stalls (hopper_ready); coins while busy are rejected.
module vending_ctrl_param
  import vending_ctrl_param_pkg::*;
#(
  parameter int                          NUM_PROD    = 4,
  parameter int                          SEL_W       = 2,
  parameter int                          CREDIT_W    = 8,
  parameter logic [NUM_PROD*CREDIT_W-1:0] PRICES     = {8'd20, 8'd15, 8'd10, 8'd5},
  parameter int                          CREDIT_MAX  = 50,
  parameter int                          TIMEOUT_CYC = 1000
) (
  input logic                 clk,
  input logic                 rst_n,
  vending_ctrl_param_if.slave bus
);

  localparam logic [CREDIT_W-1:0] CMAX  = CREDIT_W'(CREDIT_MAX);
  localparam int                  CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  // Parameter sanity: reject price tables the coin set cannot pay or exceed the ceiling.
  if (NUM_PROD < 2 || (1 << SEL_W) < NUM_PROD) begin : g_bad_sel
    $error("vending_ctrl_param: NUM_PROD/SEL_W combination is invalid");
  end
  for (genvar i = 0; i < NUM_PROD; i++) begin : g_price_chk
    localparam int P = int'(PRICES[i*CREDIT_W +: CREDIT_W]);
    if (P == 0 || (P % COIN5_VAL) != 0 || P > CREDIT_MAX) begin : g_bad_price
      $error("vending_ctrl_param: price %0d of product %0d is invalid", P, i);
    end
  end

  state_t              state, state_nxt;
  logic [CREDIT_W-1:0] credit_q, credit_nxt;
  logic [CNT_W-1:0]    idle_cnt, idle_cnt_nxt;
  logic                vend_valid_q, vend_valid_nxt;
  logic [SEL_W-1:0]    vend_id_q, vend_id_nxt;
  logic                coin_reject_q, coin_reject_nxt;
  logic                sel_err_q, sel_err_nxt;
  logic                busy_q;

  logic [CREDIT_W-1:0] price;
  logic [CREDIT_W-1:0] coin_add;
  logic                any_coin;
  logic                coins_fit;
  logic                sel_ok;
  logic                timeout_hit;

  logic                load;
  logic                done;
  logic [CREDIT_W-1:0] remaining;

  assign any_coin    = bus.coin5 | bus.coin10;
  assign coin_add    = CREDIT_W'(coin_sum(bus.coin5, bus.coin10));
  // Headroom form avoids wrap-around when credit sits near the ceiling.
  assign coins_fit   = (coin_add <= (CMAX - credit_q));
  assign sel_ok      = ({1'b0, bus.sel} < (SEL_W+1)'(NUM_PROD));
  assign timeout_hit = (TIMEOUT_CYC != 0) && (idle_cnt == CNT_LAST);

  // Price lookup for the selected product; out-of-range indices read as zero.
  always_comb begin
    price = '0;
    for (int i = 0; i < NUM_PROD; i++) begin
      if (bus.sel == SEL_W'(i)) price = PRICES[i*CREDIT_W +: CREDIT_W];
    end
  end

  // Change and refund share one dispenser; it always starts from the held credit.
  vending_ctrl_param_change_dispenser #(
    .CREDIT_W (CREDIT_W)
  ) u_dispenser (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (load),
    .amount       (credit_q),
    .hopper_ready (bus.hopper_ready),
    .chg5         (bus.chg5),
    .chg10        (bus.chg10),
    .done         (done),
    .remaining    (remaining)
  );

  // Next-state, credit and response-pulse decode.
  always_comb begin
    state_nxt       = state;
    credit_nxt      = credit_q;
    idle_cnt_nxt    = '0;
    vend_valid_nxt  = 1'b0;
    vend_id_nxt     = '0;
    coin_reject_nxt = 1'b0;
    sel_err_nxt     = 1'b0;
    load            = 1'b0;
    case (state)
      IDLE: begin
        sel_err_nxt = bus.sel_valid;
        if (any_coin) begin
          if (coins_fit) begin
            credit_nxt = credit_q + coin_add;
            state_nxt  = COLLECT;
          end else begin
            coin_reject_nxt = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (bus.cancel) begin
          coin_reject_nxt = any_coin;
          load            = 1'b1;
          credit_nxt      = '0;
          state_nxt       = CHANGE;
        end else if (bus.sel_valid) begin
          coin_reject_nxt = any_coin;
          if (!sel_ok || credit_q < price) begin
            sel_err_nxt = 1'b1;
          end else begin
            credit_nxt     = credit_q - price;
            vend_valid_nxt = 1'b1;
            vend_id_nxt    = bus.sel;
            state_nxt      = VEND;
          end
        end else if (any_coin) begin
          if (coins_fit) credit_nxt = credit_q + coin_add;
          else           coin_reject_nxt = 1'b1;
        end else if (timeout_hit) begin
          load       = 1'b1;
          credit_nxt = '0;
          state_nxt  = CHANGE;
        end else if (TIMEOUT_CYC != 0) begin
          idle_cnt_nxt = idle_cnt + 1'b1;
        end
      end
      VEND: begin
        coin_reject_nxt = any_coin;
        if (credit_q != '0) begin
          load       = 1'b1;
          credit_nxt = '0;
          state_nxt  = CHANGE;
        end else begin
          state_nxt = IDLE;
        end
      end
      CHANGE: begin
        coin_reject_nxt = any_coin;
        if (done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, credit, idle counter and registered response pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      credit_q      <= '0;
      idle_cnt      <= '0;
      vend_valid_q  <= 1'b0;
      vend_id_q     <= '0;
      coin_reject_q <= 1'b0;
      sel_err_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state         <= state_nxt;
      credit_q      <= credit_nxt;
      idle_cnt      <= idle_cnt_nxt;
      vend_valid_q  <= vend_valid_nxt;
      vend_id_q     <= vend_id_nxt;
      coin_reject_q <= coin_reject_nxt;
      sel_err_q     <= sel_err_nxt;
      busy_q        <= (state_nxt == VEND) || (state_nxt == CHANGE);
    end
  end

  assign bus.vend_valid  = vend_valid_q;
  assign bus.vend_id     = vend_id_q;
  assign bus.coin_reject = coin_reject_q;
  assign bus.sel_err     = sel_err_q;
  assign bus.busy        = busy_q;
  // While paying out, the held credit lives in the dispenser.
  assign bus.credit      = (state == CHANGE) ? remaining : credit_q;

endmodule

// File: tb/tb_vending_ctrl_param.sv
// Directed bench for vending_ctrl_param with default parameters.
// Latency: responses checked at the falling edge after the sampling rising edge.
// Backpressure: hopper_ready is driven low for stall and reset-mid-change cases.
module tb_vending_ctrl_param;

  logic clk;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   paid;

  vending_ctrl_param_if #(.SEL_W(2), .CREDIT_W(8)) bus ();

  vending_ctrl_param #(
    .NUM_PROD    (4),
    .SEL_W       (2),
    .CREDIT_W    (8),
    .PRICES      ({8'd20, 8'd15, 8'd10, 8'd5}),
    .CREDIT_MAX  (50),
    .TIMEOUT_CYC (1000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output word: {vend_valid, vend_id, chg5, chg10, coin_reject, sel_err, credit, busy}
  function automatic logic [31:0] ex(input logic vv, input logic [1:0] id, input logic c5,
                                     input logic c10, input logic rej, input logic se,
                                     input logic [7:0] cr, input logic b);
    return {16'd0, vv, id, c5, c10, rej, se, cr, b};
  endfunction

  function automatic logic [31:0] outs();
    return {16'd0, bus.vend_valid, bus.vend_id, bus.chg5, bus.chg10, bus.coin_reject,
            bus.sel_err, bus.credit, bus.busy};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step(input logic c5, input logic c10, input logic sv,
                      input logic [1:0] s, input logic cn);
    bus.coin5     = c5;
    bus.coin10    = c10;
    bus.sel_valid = sv;
    bus.sel       = s;
    bus.cancel    = cn;
    tick();
    bus.coin5     = 1'b0;
    bus.coin10    = 1'b0;
    bus.sel_valid = 1'b0;
    bus.cancel    = 1'b0;
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.coin5        = 1'b0;
    bus.coin10       = 1'b0;
    bus.sel_valid    = 1'b0;
    bus.sel          = 2'd0;
    bus.cancel       = 1'b0;
    bus.hopper_ready = 1'b1;
    tick();
    tick();
    chk("reset_outputs", outs(), ex(0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    tick();
    chk("after_release", outs(), ex(0, 0, 0, 0, 0, 0, 0, 0));

    // Exact payment: 10+10, product 3 costs 20.
    step(0, 1, 0, 0, 0);
    chk("exact_coin1", outs(), ex(0, 0, 0, 0, 0, 0, 10, 0));
    step(0, 1, 0, 0, 0);
    chk("exact_coin2", outs(), ex(0, 0, 0, 0, 0, 0, 20, 0));
    step(0, 0, 1, 3, 0);
    chk("exact_vend", outs(), ex(1, 3, 0, 0, 0, 0, 0, 1));
    tick();
    chk("exact_idle", outs(), ex(0, 0, 0, 0, 0, 0, 0, 0));

    // Change: 20 paid for product 2 (15), one 5 coin back.
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("chg_credit20", outs(), ex(0, 0, 0, 0, 0, 0, 20, 0));
    step(0, 0, 1, 2, 0);
    chk("chg_vend", outs(), ex(1, 2, 0, 0, 0, 0, 5, 1));
    tick();
    chk("chg_pay5", outs(), ex(0, 0, 1, 0, 0, 0, 5, 1));
    tick();
    chk("chg_idle", outs(), ex(0, 0, 0, 0, 0, 0, 0, 0));

    // Stalled change: 35 credit, product 0 (5), hopper stalls 3 cycles, coin refused while busy.
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("stall_credit35", outs(), ex(0, 0, 0, 0, 0, 0, 35, 0));
    bus.hopper_ready = 1'b0;
    step(0, 0, 1, 0, 0);
    chk("stall_vend", outs(), ex(1, 0, 0, 0, 0, 0, 30, 1));
    tick();
    chk("stall_wait1", outs(), ex(0, 0, 0, 0, 0, 0, 30, 1));
    step(1, 0, 0, 0, 0);
    chk("stall_busy_reject", outs(), ex(0, 0, 0, 0, 1, 0, 30, 1));
    tick();
    chk("stall_wait3", outs(), ex(0, 0, 0, 0, 0, 0, 30, 1));
    bus.hopper_ready = 1'b1;
    #1;
    chk("stall_beat1", outs(), ex(0, 0, 0, 1, 0, 0, 30, 1));
    tick();
    chk("stall_beat2", outs(), ex(0, 0, 0, 1, 0, 0, 20, 1));
    tick();
    chk("stall_beat3", outs(), ex(0, 0, 0, 1, 0, 0, 10, 1));
    tick();
    chk("stall_idle", outs(), ex(0, 0, 0, 0, 0, 0, 0, 0));

    // Overflow: 45 credit, 5+10 together refused, 5 alone reaches the 50 ceiling.
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("ovf_credit45", outs(), ex(0, 0, 0, 0, 0, 0, 45, 0));
    step(1, 1, 0, 0, 0);
    chk("ovf_both_reject", outs(), ex(0, 0, 0, 0, 1, 0, 45, 0));
    step(1, 0, 0, 0, 0);
    chk("ovf_fill50", outs(), ex(0, 0, 0, 0, 0, 0, 50, 0));
    step(1, 0, 0, 0, 0);
    chk("ovf_full_reject", outs(), ex(0, 0, 0, 0, 1, 0, 50, 0));
    step(0, 0, 0, 0, 1);
    chk("ovf_refund_start", outs(), ex(0, 0, 0, 1, 0, 0, 50, 1));
    paid = 0;
    for (int i = 0; i < 20 && bus.busy; i++) begin
      paid += bus.chg10 ? 10 : (bus.chg5 ? 5 : 0);
      tick();
    end
    chk("ovf_refund_total", 32'(paid), 32'd50);
    chk("ovf_idle", outs(), ex(0, 0, 0, 0, 0, 0, 0, 0));

    // Errors: selection in IDLE, cancel in IDLE ignored, too little credit, then cancel refund.
    step(0, 0, 1, 1, 0);
    chk("err_sel_idle", outs(), ex(0, 0, 0, 0, 0, 1, 0, 0));
    step(0, 0, 0, 0, 1);
    chk("err_cancel_idle", outs(), ex(0, 0, 0, 0, 0, 0, 0, 0));
    step(0, 1, 0, 0, 0);
    chk("err_credit10", outs(), ex(0, 0, 0, 0, 0, 0, 10, 0));
    step(0, 0, 1, 3, 0);
    chk("err_short_credit", outs(), ex(0, 0, 0, 0, 0, 1, 10, 0));
    step(0, 0, 0, 0, 1);
    chk("err_cancel_refund", outs(), ex(0, 0, 0, 1, 0, 0, 10, 1));
    tick();
    chk("err_idle", outs(), ex(0, 0, 0, 0, 0, 0, 0, 0));

    // Timeout: 15 credit, 1000 idle cycles then refund 10 + 5.
    step(1, 1, 0, 0, 0);
    chk("to_credit15", outs(), ex(0, 0, 0, 0, 0, 0, 15, 0));
    repeat (999) tick();
    chk("to_not_yet", outs(), ex(0, 0, 0, 0, 0, 0, 15, 0));
    tick();
    chk("to_refund10", outs(), ex(0, 0, 0, 1, 0, 0, 15, 1));
    tick();
    chk("to_refund5", outs(), ex(0, 0, 1, 0, 0, 0, 5, 1));
    tick();
    chk("to_idle", outs(), ex(0, 0, 0, 0, 0, 0, 0, 0));

    // Reset in the middle of a refund discards the remaining change.
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("rst_refund_start", outs(), ex(0, 0, 0, 1, 0, 0, 20, 1));
    bus.hopper_ready = 1'b0;
    #1;
    chk("rst_stalled", outs(), ex(0, 0, 0, 0, 0, 0, 20, 1));
    rst_n = 1'b0;
    #1;
    chk("rst_async_clear", outs(), ex(0, 0, 0, 0, 0, 0, 0, 0));
    bus.hopper_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_no_resume", outs(), ex(0, 0, 0, 0, 0, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
